// File: rtl/adder_measure_pkg.sv
// Shared types and default sizing for the adder measurement sequencer.
package adder_measure_pkg;

    localparam int COUNT_W_DEF = 32;
    localparam int RUNS_W_DEF  = 8;
    localparam int ACC_W_DEF   = 40;
    localparam int GUARD_DEF   = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        LOAD    = 3'd2,
        RUN     = 3'd3,
        CAPTURE = 3'd4,
        DONE    = 3'd5
    } state_t;

endpackage

// File: rtl/measure_accumulator.sv
// Saturating count accumulator and run counter; min/max tracking is built
// only when MEASURE_MINMAX_EN is defined.
module measure_accumulator
    import adder_measure_pkg::*;
#(
    parameter int COUNT_W = COUNT_W_DEF,
    parameter int RUNS_W  = RUNS_W_DEF,
    parameter int ACC_W   = ACC_W_DEF
) (
    input  logic               clk,
    input  logic               reset_b,
    input  logic               clear_i,
    input  logic               capture_i,
    input  logic [COUNT_W-1:0] count_i,
    output logic [ACC_W-1:0]   acc_o,
    output logic [RUNS_W-1:0]  runs_o,
    output logic [COUNT_W-1:0] min_o,
    output logic [COUNT_W-1:0] max_o
);

    // Sum width covers the case where the accumulator is narrower than a count.
    localparam int SUM_W = ((ACC_W > COUNT_W) ? ACC_W : COUNT_W) + 1;
    localparam logic [RUNS_W-1:0] RUNS_ONE = {{(RUNS_W-1){1'b0}}, 1'b1};

    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                 input logic [COUNT_W-1:0] b);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(b);
        if (s > SUM_W'({ACC_W{1'b1}})) begin
            sat_add = {ACC_W{1'b1}};
        end else begin
            sat_add = s[ACC_W-1:0];
        end
    endfunction

    logic [ACC_W-1:0]  acc_q,  acc_d;
    logic [RUNS_W-1:0] runs_q, runs_d;

    // Next-state for accumulator and run counter.
    always_comb begin
        acc_d  = acc_q;
        runs_d = runs_q;
        if (clear_i) begin
            acc_d  = {ACC_W{1'b0}};
            runs_d = {RUNS_W{1'b0}};
        end else if (capture_i) begin
            acc_d  = sat_add(acc_q, count_i);
            runs_d = runs_q + RUNS_ONE;
        end else begin
            acc_d  = acc_q;
            runs_d = runs_q;
        end
    end

    // Accumulator and run counter registers.
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            acc_q  <= {ACC_W{1'b0}};
            runs_q <= {RUNS_W{1'b0}};
        end else begin
            acc_q  <= acc_d;
            runs_q <= runs_d;
        end
    end

    assign acc_o  = acc_q;
    assign runs_o = runs_q;

`ifdef MEASURE_MINMAX_EN
    logic [COUNT_W-1:0] min_q, min_d;
    logic [COUNT_W-1:0] max_q, max_d;

    // First capture seeds both extremes; later captures compare.
    always_comb begin
        min_d = min_q;
        max_d = max_q;
        if (clear_i) begin
            min_d = {COUNT_W{1'b0}};
            max_d = {COUNT_W{1'b0}};
        end else if (capture_i) begin
            if (runs_q == {RUNS_W{1'b0}}) begin
                min_d = count_i;
                max_d = count_i;
            end else begin
                if (count_i < min_q) begin
                    min_d = count_i;
                end else begin
                    min_d = min_q;
                end
                if (count_i > max_q) begin
                    max_d = count_i;
                end else begin
                    max_d = max_q;
                end
            end
        end else begin
            min_d = min_q;
            max_d = max_q;
        end
    end

    // Min/max registers.
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            min_q <= {COUNT_W{1'b0}};
            max_q <= {COUNT_W{1'b0}};
        end else begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end

    assign min_o = min_q;
    assign max_o = max_q;
`else
    assign min_o = {COUNT_W{1'b0}};
    assign max_o = {COUNT_W{1'b0}};
`endif

endmodule

// File: rtl/adder_measure_sequencer.sv
// Runs N integration windows on instrumented_adder and reports the summed count.
// Optional min/max reporting is enabled by defining MEASURE_MINMAX_EN.
module adder_measure_sequencer
    import adder_measure_pkg::*;
#(
    parameter int COUNT_W = COUNT_W_DEF,
    parameter int RUNS_W  = RUNS_W_DEF,
    parameter int ACC_W   = ACC_W_DEF,
    parameter int GUARD   = GUARD_DEF
) (
    input  logic               clk,
    input  logic               reset_b,
    input  logic               start,
    input  logic [RUNS_W-1:0]  num_runs,
    input  logic [COUNT_W-1:0] integration_time,
    output logic               busy,
    output logic               adder_reset,
    output logic               adder_counter_load,
    output logic               adder_counter_enable,
    output logic [COUNT_W-1:0] adder_integration_time,
    input  logic               adder_done,
    input  logic [COUNT_W-1:0] adder_count,
    output logic               result_valid,
    input  logic               result_ready,
    output logic [ACC_W-1:0]   result_acc,
    output logic [RUNS_W-1:0]  result_runs,
    output logic               result_timeout,
    output logic [COUNT_W-1:0] result_min,
    output logic [COUNT_W-1:0] result_max
);

    localparam int WD_W = COUNT_W + 1;
    localparam logic [WD_W-1:0]   WD_ZERO   = {WD_W{1'b0}};
    localparam logic [WD_W-1:0]   WD_ONE    = {{COUNT_W{1'b0}}, 1'b1};
    localparam logic [WD_W-1:0]   GUARD_EXT = WD_W'(GUARD);
    localparam logic [RUNS_W-1:0] RUNS_ONE  = {{(RUNS_W-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [RUNS_W-1:0]  target_q, target_d;
    logic [COUNT_W-1:0] itime_q, itime_d;
    logic [WD_W-1:0]    limit_q, limit_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic               timeout_q, timeout_d;
    logic               busy_q, reset_q, load_q, enable_q, valid_q;
    logic [COUNT_W-1:0] adder_itime_q, adder_itime_d;
    logic               acc_clear_s, acc_capture_s;
    logic [RUNS_W-1:0]  runs_next_s;

    assign runs_next_s = result_runs + RUNS_ONE;

    // Sequencer next-state, watchdog and accumulator strobes.
    always_comb begin
        state_d       = state_q;
        target_d      = target_q;
        itime_d       = itime_q;
        limit_d       = limit_q;
        wd_d          = wd_q;
        timeout_d     = timeout_q;
        acc_clear_s   = 1'b0;
        acc_capture_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_runs == {RUNS_W{1'b0}}) begin
                        target_d = RUNS_ONE;
                    end else begin
                        target_d = num_runs;
                    end
                    itime_d     = integration_time;
                    limit_d     = {1'b0, integration_time} + GUARD_EXT;
                    timeout_d   = 1'b0;
                    acc_clear_s = 1'b1;
                    state_d     = CLEAR;
                end else begin
                    state_d = IDLE;
                end
            end
            CLEAR: state_d = LOAD;
            LOAD: begin
                wd_d    = WD_ZERO;
                state_d = RUN;
            end
            RUN: begin
                // done is blanked while the watchdog still reads zero; done beats expiry.
                if (adder_done && (wd_q != WD_ZERO)) begin
                    state_d = CAPTURE;
                end else if ((wd_q + WD_ONE) >= limit_q) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    wd_d = wd_q + WD_ONE;
                end
            end
            CAPTURE: begin
                acc_capture_s = 1'b1;
                if (runs_next_s == target_q) begin
                    state_d = DONE;
                end else begin
                    state_d = CLEAR;
                end
            end
            DONE: begin
                if (result_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        if (state_d == LOAD) begin
            adder_itime_d = itime_q;
        end else begin
            adder_itime_d = adder_itime_q;
        end
    end

    // State, latched request and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            state_q       <= IDLE;
            target_q      <= {RUNS_W{1'b0}};
            itime_q       <= {COUNT_W{1'b0}};
            limit_q       <= WD_ZERO;
            wd_q          <= WD_ZERO;
            timeout_q     <= 1'b0;
            busy_q        <= 1'b0;
            reset_q       <= 1'b0;
            load_q        <= 1'b0;
            enable_q      <= 1'b0;
            valid_q       <= 1'b0;
            adder_itime_q <= {COUNT_W{1'b0}};
        end else begin
            state_q       <= state_d;
            target_q      <= target_d;
            itime_q       <= itime_d;
            limit_q       <= limit_d;
            wd_q          <= wd_d;
            timeout_q     <= timeout_d;
            busy_q        <= (state_d != IDLE);
            reset_q       <= (state_d == CLEAR);
            load_q        <= (state_d == LOAD);
            enable_q      <= (state_d == RUN);
            valid_q       <= (state_d == DONE);
            adder_itime_q <= adder_itime_d;
        end
    end

    assign busy                   = busy_q;
    assign adder_reset            = reset_q;
    assign adder_counter_load     = load_q;
    assign adder_counter_enable   = enable_q;
    assign adder_integration_time = adder_itime_q;
    assign result_valid           = valid_q;
    assign result_timeout         = timeout_q;

    measure_accumulator #(
        .COUNT_W (COUNT_W),
        .RUNS_W  (RUNS_W),
        .ACC_W   (ACC_W)
    ) u_acc (
        .clk       (clk),
        .reset_b   (reset_b),
        .clear_i   (acc_clear_s),
        .capture_i (acc_capture_s),
        .count_i   (adder_count),
        .acc_o     (result_acc),
        .runs_o    (result_runs),
        .min_o     (result_min),
        .max_o     (result_max)
    );

endmodule

// File: tb/tb_adder_measure_sequencer.sv
// Bench for adder_measure_sequencer: an adder model, a result model and one
// per-cycle compare process; a second instance uses an 8-bit accumulator.
module tb_adder_measure_sequencer;

    localparam int CW  = 32;
    localparam int RW  = 8;
    localparam int AW  = 40;
    localparam int AW2 = 8;
    localparam int G   = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_b = 1'b0;
    logic          start = 1'b0;
    logic          result_ready = 1'b1;
    logic [RW-1:0] num_runs = '0;
    logic [CW-1:0] integration_time = '0;
    logic          adder_done = 1'b0;
    logic [CW-1:0] adder_count = '0;

    logic          busy, adder_reset, adder_counter_load, adder_counter_enable;
    logic [CW-1:0] adder_integration_time;
    logic          result_valid, result_timeout;
    logic [AW-1:0] result_acc;
    logic [RW-1:0] result_runs;
    logic [CW-1:0] result_min, result_max;

    logic           busy2, adder_reset2, adder_load2, adder_enable2;
    logic [CW-1:0]  adder_itime2;
    logic           result_valid2, result_timeout2;
    logic [AW2-1:0] result_acc2;
    logic [RW-1:0]  result_runs2;
    logic [CW-1:0]  result_min2, result_max2;

    adder_measure_sequencer #(.COUNT_W(CW), .RUNS_W(RW), .ACC_W(AW), .GUARD(G)) dut (
        .clk(clk), .reset_b(reset_b), .start(start), .num_runs(num_runs),
        .integration_time(integration_time), .busy(busy), .adder_reset(adder_reset),
        .adder_counter_load(adder_counter_load), .adder_counter_enable(adder_counter_enable),
        .adder_integration_time(adder_integration_time), .adder_done(adder_done),
        .adder_count(adder_count), .result_valid(result_valid), .result_ready(result_ready),
        .result_acc(result_acc), .result_runs(result_runs), .result_timeout(result_timeout),
        .result_min(result_min), .result_max(result_max));

    adder_measure_sequencer #(.COUNT_W(CW), .RUNS_W(RW), .ACC_W(AW2), .GUARD(G)) dut8 (
        .clk(clk), .reset_b(reset_b), .start(start), .num_runs(num_runs),
        .integration_time(integration_time), .busy(busy2), .adder_reset(adder_reset2),
        .adder_counter_load(adder_load2), .adder_counter_enable(adder_enable2),
        .adder_integration_time(adder_itime2), .adder_done(adder_done),
        .adder_count(adder_count), .result_valid(result_valid2), .result_ready(result_ready),
        .result_acc(result_acc2), .result_runs(result_runs2), .result_timeout(result_timeout2),
        .result_min(result_min2), .result_max(result_max2));

    // Stimulus-side settings (written only by the main initial block).
    int cnt_tab [4];
    int done_after = 0;
    longint exp_acc = 0, exp_acc2 = 0;
    int exp_runs = 0, exp_to = 0, exp_min = 0, exp_max = 0, exp_itime = 0;
    int lit_en = 0, lit_acc = 0, lit_runs = 0, lit_to = 0, lit_len = 0, lit_clr = 0;
    int lit_vlen = 0, lit_acc2 = 0, lit_min = 0, lit_max = 0;
    int tmo_req = 0;

    // Adder model: done rises after done_after enable cycles, count from the table.
    int ecnt = 0, run_idx = 0;
    always @(negedge clk) begin
        if (start) run_idx = 0;
        if (!reset_b || adder_reset) begin
            ecnt = 0;
            adder_done = 1'b0;
        end else if (adder_counter_enable && !adder_done) begin
            ecnt++;
            if (done_after != 0 && ecnt == done_after) begin
                adder_done = 1'b1;
                if (run_idx < 4) adder_count = CW'(cnt_tab[run_idx]);
                run_idx++;
            end
        end
    end

    int vec_cnt = 0, miss_cnt = 0;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        vec_cnt++;
        if (act !== expv) begin
            miss_cnt++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    // Compare process: protocol, reset values and result model, once per cycle.
    int clr_cnt = 0, en_len = 0, vlen = 0, tmo_seen = 0;
    bit seen_rst = 0, p_rstlow = 0, p_rst = 0, p_load = 0, p_acc = 0;
    always @(negedge clk) begin
        if (start && !busy) clr_cnt = 0;
        else if (adder_reset) clr_cnt++;
        if (adder_reset) en_len = 0;
        else if (adder_counter_enable) en_len++;
        if (result_valid) vlen++;
        else vlen = 0;

        if (tmo_req != tmo_seen) begin
            chk("wait_bound", 64'd1, 64'd0);
            tmo_seen = tmo_req;
        end
        if (p_rstlow) begin
            chk("rst_busy", busy, 0);
            chk("rst_ctl", {adder_reset, adder_counter_load, adder_counter_enable}, 0);
            chk("rst_itime", adder_integration_time, 0);
            chk("rst_valid", result_valid, 0);
            chk("rst_acc", result_acc, 0);
            chk("rst_runs", result_runs, 0);
            chk("rst_timeout", result_timeout, 0);
            chk("rst_minmax", {result_min, result_max}, 0);
            chk("rst_acc8", result_acc2, 0);
        end
        if (seen_rst && reset_b) begin
            chk("ctl_onehot", 64'($countones({adder_reset, adder_counter_load,
                                              adder_counter_enable}) <= 1), 64'd1);
            if (!busy) chk("ctl_idle", {adder_reset, adder_counter_load, adder_counter_enable}, 0);
            if (p_rst) chk("load_after_clear", adder_counter_load, 1);
            if (p_load) chk("enable_after_load", adder_counter_enable, 1);
            if (adder_counter_load) chk("load_itime", adder_integration_time, exp_itime);
            if (p_acc) begin
                chk("accept_valid_drop", result_valid, 0);
                chk("accept_busy_drop", busy, 0);
            end
            if (result_valid || !busy) begin
                if (result_valid) chk("valid_busy", busy, 1);
                chk("res_acc", result_acc, exp_acc);
                chk("res_runs", result_runs, exp_runs);
                chk("res_timeout", result_timeout, exp_to);
                chk("res_min", result_min, exp_min);
                chk("res_max", result_max, exp_max);
                chk("res_acc8", result_acc2, exp_acc2);
                chk("res_runs8", result_runs2, exp_runs);
            end
            if (result_valid && result_ready && lit_en != 0) begin
                chk("lit_acc", result_acc, lit_acc);
                chk("lit_runs", result_runs, lit_runs);
                chk("lit_timeout", result_timeout, lit_to);
                chk("lit_run_len", en_len, lit_len);
                chk("lit_clears", clr_cnt, lit_clr);
                chk("lit_valid_len", vlen, lit_vlen);
                chk("lit_acc8", result_acc2, lit_acc2);
`ifdef MEASURE_MINMAX_EN
                chk("lit_min", result_min, lit_min);
                chk("lit_max", result_max, lit_max);
`endif
            end
        end
        p_acc    = result_valid && result_ready;
        p_rst    = adder_reset;
        p_load   = adder_counter_load;
        p_rstlow = !reset_b;
        if (!reset_b) seen_rst = 1;
    end

    // Result model: saturating sum, run count and extremes of the requested runs.
    task automatic compute_exp(input int nr, input int it, input int da);
        int n;
        longint s, s2, mx1, mx2;
        int mn, mx;
        n = (nr == 0) ? 1 : nr;
        mx1 = (64'sd1 <<< AW) - 1;
        mx2 = (64'sd1 <<< AW2) - 1;
        exp_itime = it;
        s = 0; s2 = 0; mn = 0; mx = 0;
        if (da == 0 || da > it + G) begin
            exp_runs = 0;
            exp_to = 1;
        end else begin
            exp_runs = n;
            exp_to = 0;
            mn = cnt_tab[0];
            mx = cnt_tab[0];
            for (int i = 0; i < n; i++) begin
                s  = s + cnt_tab[i];
                s2 = s2 + cnt_tab[i];
                if (s > mx1) s = mx1;
                if (s2 > mx2) s2 = mx2;
                if (cnt_tab[i] < mn) mn = cnt_tab[i];
                if (cnt_tab[i] > mx) mx = cnt_tab[i];
            end
        end
        exp_acc = s;
        exp_acc2 = s2;
`ifdef MEASURE_MINMAX_EN
        exp_min = mn;
        exp_max = mx;
`else
        exp_min = 0;
        exp_max = 0;
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic measure(input int nr, input int it, input int da);
        step();
        num_runs = RW'(nr);
        integration_time = CW'(it);
        done_after = da;
        start = 1'b1;
        step();
        start = 1'b0;
        compute_exp(nr, it, da);
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!result_valid && n < budget) begin
            step();
            n++;
        end
        if (!result_valid) tmo_req++;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        step();
        while (busy && n < budget) begin
            step();
            n++;
        end
        if (busy) tmo_req++;
    endtask

    task automatic set_lit(input int a, input int r, input int t, input int len, input int clr,
                           input int vl, input int a8, input int mn, input int mx);
        lit_en = 1; lit_acc = a; lit_runs = r; lit_to = t; lit_len = len; lit_clr = clr;
        lit_vlen = vl; lit_acc2 = a8; lit_min = mn; lit_max = mx;
    endtask

    initial begin
        repeat (3) step();
        reset_b = 1'b1;
        repeat (2) step();

        // Four runs of 100 cycles.
        cnt_tab = '{10, 20, 30, 40};
        set_lit(100, 4, 0, 100, 4, 1, 100, 10, 40);
        measure(4, 100, 100);
        wait_valid(2000);
        wait_idle(10);

        // Zero runs requested behaves as one.
        cnt_tab = '{7, 0, 0, 0};
        set_lit(7, 1, 0, 5, 1, 1, 7, 7, 7);
        measure(0, 5, 5);
        wait_valid(200);
        wait_idle(10);

        // done never comes: timeout after integration_time + GUARD RUN cycles.
        set_lit(0, 0, 1, 66, 1, 1, 0, 0, 0);
        measure(3, 50, 0);
        wait_valid(200);
        wait_idle(10);

        // Consumer stalls for 20 cycles; a start during DONE is ignored.
        cnt_tab = '{3, 9, 0, 0};
        result_ready = 1'b0;
        set_lit(12, 2, 0, 10, 2, 21, 12, 3, 9);
        measure(2, 10, 10);
        wait_valid(200);
        repeat (9) step();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (10) step();
        result_ready = 1'b1;
        wait_idle(10);

        // Saturation on the 8-bit accumulator instance.
        cnt_tab = '{200, 200, 0, 0};
        set_lit(400, 2, 0, 8, 2, 1, 255, 200, 200);
        measure(2, 8, 8);
        wait_valid(200);
        wait_idle(10);

        // Reset during the second run, then a clean measurement.
        begin
            int rises = 1, n = 0;
            bit prev = 1;
            lit_en = 0;
            cnt_tab = '{1, 2, 3, 0};
            measure(3, 20, 20);
            while (rises < 2 && n < 200) begin
                step();
                if (adder_reset && !prev) rises++;
                prev = adder_reset;
                n++;
            end
            if (rises < 2) tmo_req++;
            repeat (6) step();
            reset_b = 1'b0;
            exp_acc = 0; exp_acc2 = 0; exp_runs = 0; exp_to = 0; exp_min = 0; exp_max = 0;
            step();
            reset_b = 1'b1;
            step();
        end
        cnt_tab = '{5, 6, 0, 0};
        set_lit(11, 2, 0, 12, 2, 1, 11, 5, 6);
        measure(2, 12, 12);
        wait_valid(200);
        wait_idle(10);

        repeat (3) step();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish by %0t", $time);
        $fatal(1, "bench stopped");
    end

endmodule

// File: doc/adder_measure_sequencer.md
Name: adder_measure_sequencer

Overview:
- Controller directly upstream/downstream of instrumented_adder; replaces manual LA bit-banging of the counter controls.
- On a start pulse it runs N back-to-back integration windows: reset counters, load integration time, enable, wait for done, capture ring_osc_counter_out.
- Accumulates the N counts and presents one result via valid/ready handshake to the LA/wishbone readout.

Parameters:
- COUNT_W, 32, width of integration time and ring count
- RUNS_W, 8, width of run-count request
- ACC_W, 40, accumulator width (≥ COUNT_W+RUNS_W)
- GUARD, 16, extra cycles beyond integration_time before a run is declared timed out

Ports:
- clk  in  1  system clock (wb_clk_i at wrapper)
- reset_b  in  1  synchronous reset, active low
- start  in  1  single-cycle request to begin a measurement
- num_runs  in  RUNS_W  runs requested; 0 treated as 1
- integration_time  in  COUNT_W  window length passed to adder
- busy  out  1  high from start acceptance until result accepted
- adder_reset  out  1  to instrumented_adder reset
- adder_counter_load  out  1  to counter_load
- adder_counter_enable  out  1  to counter_enable
- adder_integration_time  out  COUNT_W  to integration_time
- adder_done  in  1  from done
- adder_count  in  COUNT_W  from ring_osc_counter_out
- result_valid  out  1  result available
- result_ready  in  1  consumer accepts result
- result_acc  out  ACC_W  sum of captured counts
- result_runs  out  RUNS_W  completed runs
- result_timeout  out  1  measurement aborted on timeout
- result_min  out  COUNT_W  smallest count (optional feature)
- result_max  out  COUNT_W  largest count (optional feature)

Behaviour:
- All outputs registered. Reset (reset_b=0 at clk edge): state IDLE; busy, adder_*, result_valid, result_timeout = 0; result_acc, result_runs, result_min, result_max = 0; adder_integration_time = 0.
- IDLE: start=1 latches num_runs (0→1) and integration_time, clears acc/run counter, busy=1 next cycle, → CLEAR. start ignored in all other states.
- CLEAR (1 cycle): adder_reset=1 → LOAD.
- LOAD (1 cycle): adder_counter_load=1, adder_integration_time = latched value → RUN.
- RUN: adder_counter_enable=1; watchdog counts from 0. adder_done ignored in first RUN cycle (blanking). adder_done=1 → CAPTURE, enable drops the next cycle. Watchdog reaching integration_time+GUARD (computed COUNT_W+1 bits, no wrap) → DONE with result_timeout=1.
- CAPTURE (1 cycle): acc += adder_count, saturating at 2^ACC_W-1; runs_done += 1; if runs_done == target → DONE else → CLEAR.
- DONE: result_valid=1, outputs stable; on result_valid&result_ready → IDLE, result_valid and busy drop next cycle. result_* hold last values in IDLE.
- Per-run latency: 3 cycles + cycles to done. Start-to-first adder_reset: 1 cycle.
- Simultaneous done and watchdog expiry: done wins (normal capture).
- reset_b low mid-run: immediate return to reset values; adder controls deasserted same edge.

Optional Feature:
- MEASURE_MINMAX_EN defined: CAPTURE updates result_min/result_max; first run initialises both to adder_count. Cleared on start.
- Undefined: result_min/result_max tied to 0, no comparators.

Decomposition:
- Package adder_measure_pkg: state enum (IDLE, CLEAR, LOAD, RUN, CAPTURE, DONE), default widths, GUARD constant.
- One sub-module, measure_accumulator: saturating add, run counter, optional min/max; FSM and watchdog stay in top.

Test Plan:
- num_runs=4, integration_time=100, model done after 100 enable cycles with counts 10,20,30,40 → result_acc=100, result_runs=4, result_timeout=0, min=10, max=40 (with MEASURE_MINMAX_EN).
- num_runs=0 → exactly one CLEAR/LOAD/RUN/CAPTURE; result_runs=1.
- Done never asserted, integration_time=50 → result_valid with result_timeout=1 at RUN cycle 66, result_runs=0.
- result_ready held low 20 cycles in DONE → result_valid and outputs stable; start pulse ignored; accepted on ready, busy=0 one cycle later.
- ACC_W=8 override, counts 200,200 → result_acc=255 (saturated).
- reset_b low during RUN run 2 → all outputs 0 next edge; new start runs cleanly from run 1.
